// File: rtl/ctr_retire_aligner_if.sv
// Retirement streams of the two lock-stepped runs and the paired output bundle.
// master drives the retirements (core side), slave is the aligner.
interface ctr_retire_aligner_if #(
  parameter int OBS_W = 239,
  parameter int LVL_W = 3
);
  logic             retire_1_i;
  logic [OBS_W-1:0] obs_1_i;
  logic             retire_2_i;
  logic [OBS_W-1:0] obs_2_i;
  logic             retire_o;
  logic [OBS_W-1:0] obs_1_o;
  logic [OBS_W-1:0] obs_2_o;
  logic             overflow_o;
  logic             desync_o;
  logic [31:0]      pairs_o;
  logic [LVL_W-1:0] level_1_o;
  logic [LVL_W-1:0] level_2_o;

  modport master (
    output retire_1_i, obs_1_i, retire_2_i, obs_2_i,
    input  retire_o, obs_1_o, obs_2_o, overflow_o, desync_o, pairs_o, level_1_o, level_2_o
  );

  modport slave (
    input  retire_1_i, obs_1_i, retire_2_i, obs_2_i,
    output retire_o, obs_1_o, obs_2_o, overflow_o, desync_o, pairs_o, level_1_o, level_2_o
  );
endinterface

// File: rtl/ctr_retire_aligner.sv
// Pairs the n-th retirement of run 1 with the n-th retirement of run 2.
// Each run has a small FIFO absorbing timing skew; heads are popped together
// whenever both FIFOs hold an entry, producing a one-cycle paired pulse.
// Sticky flags report dropped retirements and excessive one-sided skew.
module ctr_retire_aligner #(
  parameter int DEPTH    = 4,
  parameter int OBS_W    = 239,
  parameter int MAX_SKEW = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  ctr_retire_aligner_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(MAX_SKEW + 1);

  logic             pop;
  logic             retire_in [2];
  logic [OBS_W-1:0] obs_in [2];

  assign retire_in[0] = bus.retire_1_i;
  assign retire_in[1] = bus.retire_2_i;
  assign obs_in[0]    = bus.obs_1_i;
  assign obs_in[1]    = bus.obs_2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_run
      logic [OBS_W-1:0] mem [DEPTH];
      logic [LW-1:0]    wr_ptr_reg;
      logic [LW-1:0]    rd_ptr_reg;
      logic [OBS_W-1:0] obs_reg;
      logic [LW-1:0]    level;
      logic             empty;
      logic             full;
      logic             push;
      logic             drop;

      // Pointers carry one extra wrap bit, so their difference is the occupancy.
      assign level = wr_ptr_reg - rd_ptr_reg;
      assign empty = (level == '0);
      assign full  = (level == LW'(DEPTH));
      // A full FIFO still accepts a push when its head leaves at the same edge.
      assign push  = retire_in[gi] && (!full || pop);
      assign drop  = retire_in[gi] && full && !pop;

      // Observation storage; no reset needed since empty pointers mask contents.
      always_ff @(posedge clk_i) begin
        if (push) begin
          mem[wr_ptr_reg[AW-1:0]] <= obs_in[gi];
        end
      end

      // Pointer advance and registered head read on a pair.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          obs_reg    <= '0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + LW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + LW'(1);
            obs_reg    <= mem[rd_ptr_reg[AW-1:0]];
          end
        end
      end
    end
  endgenerate

  // Pair only when both runs have a pending retirement (state before the edge).
  assign pop = !g_run[0].empty && !g_run[1].empty;

  logic          retire_reg;
  logic          overflow_reg;
  logic          desync_reg;
  logic [31:0]   pairs_reg;
  logic [SW-1:0] skew_cnt_reg;
  logic [SW-1:0] skew_cnt_next;
  logic          one_sided;

  assign one_sided = (g_run[0].empty != g_run[1].empty);

  // Skew grows only while exactly one run has outstanding retirements.
  always_comb begin
    skew_cnt_next = '0;
    if (one_sided) begin
      if (skew_cnt_reg == SW'(MAX_SKEW)) begin
        skew_cnt_next = skew_cnt_reg;
      end else begin
        skew_cnt_next = skew_cnt_reg + SW'(1);
      end
    end
  end

  // Pair pulse, sticky flags, skew tracking and saturating pair count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      desync_reg   <= 1'b0;
      pairs_reg    <= '0;
      skew_cnt_reg <= '0;
    end else begin
      retire_reg   <= pop;
      overflow_reg <= overflow_reg | g_run[0].drop | g_run[1].drop;
      skew_cnt_reg <= skew_cnt_next;
      desync_reg   <= desync_reg | (skew_cnt_next == SW'(MAX_SKEW));
      if (pop && (pairs_reg != 32'hFFFF_FFFF)) begin
        pairs_reg <= pairs_reg + 32'd1;
      end
    end
  end

  assign bus.retire_o   = retire_reg;
  assign bus.obs_1_o    = g_run[0].obs_reg;
  assign bus.obs_2_o    = g_run[1].obs_reg;
  assign bus.overflow_o = overflow_reg;
  assign bus.desync_o   = desync_reg;
  assign bus.pairs_o    = pairs_reg;
  assign bus.level_1_o  = g_run[0].level;
  assign bus.level_2_o  = g_run[1].level;
endmodule

// File: tb/tb_ctr_retire_aligner.sv
// Bench for ctr_retire_aligner: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_ctr_retire_aligner;
  localparam int DEPTH    = 4;
  localparam int OBS_W    = 239;
  localparam int MAX_SKEW = 64;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  ctr_retire_aligner_if #(.OBS_W(OBS_W), .LVL_W(LW)) bus ();

  ctr_retire_aligner #(.DEPTH(DEPTH), .OBS_W(OBS_W), .MAX_SKEW(MAX_SKEW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending retirements per run and observable outputs.
  logic [OBS_W-1:0] q1 [$];
  logic [OBS_W-1:0] q2 [$];
  logic [OBS_W-1:0] m_obs1, m_obs2;
  logic             m_ret, m_ovf, m_desync;
  logic [31:0]      m_pairs;
  int               m_skew;

  typedef struct {
    logic       r1;
    logic       r2;
    logic [7:0] t1;
    logic [7:0] t2;
    logic       exp_ret;
    logic [7:0] exp_o1;
    logic [7:0] exp_o2;
    int         exp_l1;
    int         exp_l2;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [OBS_W-1:0] act, input logic [OBS_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q1.delete();
    q2.delete();
    m_obs1 = '0; m_obs2 = '0;
    m_ret = 1'b0; m_ovf = 1'b0; m_desync = 1'b0;
    m_pairs = '0; m_skew = 0;
  endtask

  function automatic logic [OBS_W-1:0] rand_obs();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[OBS_W-1:0];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".retire"},   OBS_W'(bus.retire_o),   OBS_W'(m_ret));
    chk({tag, ".obs_1"},    bus.obs_1_o,            m_obs1);
    chk({tag, ".obs_2"},    bus.obs_2_o,            m_obs2);
    chk({tag, ".overflow"}, OBS_W'(bus.overflow_o), OBS_W'(m_ovf));
    chk({tag, ".desync"},   OBS_W'(bus.desync_o),   OBS_W'(m_desync));
    chk({tag, ".pairs"},    OBS_W'(bus.pairs_o),    OBS_W'(m_pairs));
    chk({tag, ".level_1"},  OBS_W'(bus.level_1_o),  OBS_W'(q1.size()));
    chk({tag, ".level_2"},  OBS_W'(bus.level_2_o),  OBS_W'(q2.size()));
  endtask

  // One clock cycle: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic r1, input logic [OBS_W-1:0] o1,
                      input logic r2, input logic [OBS_W-1:0] o2);
    int  n1, n2;
    logic pair;
    @(negedge clk);
    bus.retire_1_i = r1; bus.obs_1_i = o1;
    bus.retire_2_i = r2; bus.obs_2_i = o2;
    n1 = q1.size();
    n2 = q2.size();
    pair = (n1 > 0) && (n2 > 0);
    m_ret = pair;
    if (pair) begin
      m_obs1 = q1.pop_front();
      m_obs2 = q2.pop_front();
      if (m_pairs != 32'hFFFF_FFFF) m_pairs = m_pairs + 32'd1;
    end
    if (r1) begin
      if (n1 < DEPTH || pair) q1.push_back(o1); else m_ovf = 1'b1;
    end
    if (r2) begin
      if (n2 < DEPTH || pair) q2.push_back(o2); else m_ovf = 1'b1;
    end
    if ((n1 > 0) != (n2 > 0)) m_skew = (m_skew < MAX_SKEW) ? m_skew + 1 : MAX_SKEW;
    else m_skew = 0;
    if (m_skew >= MAX_SKEW) m_desync = 1'b1;
    @(posedge clk);
    #1;
    check_outputs(tag);
    if (bus.retire_o) $display("[TB] %s pair %0d obs_1=%h obs_2=%h", tag, bus.pairs_o, bus.obs_1_o, bus.obs_2_o);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".retire"},   OBS_W'(bus.retire_o),   '0);
    chk({tag, ".obs_1"},    bus.obs_1_o,            '0);
    chk({tag, ".obs_2"},    bus.obs_2_o,            '0);
    chk({tag, ".overflow"}, OBS_W'(bus.overflow_o), '0);
    chk({tag, ".desync"},   OBS_W'(bus.desync_o),   '0);
    chk({tag, ".pairs"},    OBS_W'(bus.pairs_o),    '0);
    chk({tag, ".level_1"},  OBS_W'(bus.level_1_o),  '0);
    chk({tag, ".level_2"},  OBS_W'(bus.level_2_o),  '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.retire_1_i = 1'b0; bus.retire_2_i = 1'b0;
    bus.obs_1_i = '0; bus.obs_2_i = '0;
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1, 1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'hA1, 8'h00, 1'b0, 8'h00, 8'h00, 1, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'hA2, 8'h00, 1'b0, 8'h00, 8'h00, 2, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'hA3, 8'h00, 1'b0, 8'h00, 8'h00, 3, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 3, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 3, 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'hB1, 1'b0, 8'h00, 8'h00, 3, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 8'hB2, 1'b1, 8'hA1, 8'hB1, 2, 1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 8'hB3, 1'b1, 8'hA2, 8'hB2, 1, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA3, 8'hB3, 0, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'hC1, 8'h00, 1'b0, 8'h00, 8'h00, 1, 0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'hC2, 8'h00, 1'b0, 8'h00, 8'h00, 2, 0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 8'h00, 8'h00, 3, 0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 8'hC4, 8'h00, 1'b0, 8'h00, 8'h00, 4, 0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 8'hC5, 8'h00, 1'b0, 8'h00, 8'h00, 4, 0, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 8'h00, 8'hD1, 1'b0, 8'h00, 8'h00, 4, 1, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 8'h00, 8'hD2, 1'b1, 8'hC1, 8'hD1, 3, 1, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 8'h00, 8'hD3, 1'b1, 8'hC2, 8'hD2, 2, 1, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 8'h00, 8'hD4, 1'b1, 8'hC3, 8'hD3, 1, 1, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC4, 8'hD4, 0, 0, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 1'b1};

    bus.retire_1_i = 1'b0; bus.retire_2_i = 1'b0;
    bus.obs_1_i = '0; bus.obs_2_i = '0;
    rst_n = 1'b1;
    model_clear();
    #1 rst_n = 1'b0;
    #11 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: simultaneous pair, delayed run 2, overflow at DEPTH.
    for (int i = 0; i < 24; i++) begin
      step($sformatf("vec%0d", i), tbl[i].r1, OBS_W'(tbl[i].t1), tbl[i].r2, OBS_W'(tbl[i].t2));
      chk($sformatf("vec%0d.retire", i),   OBS_W'(bus.retire_o),   OBS_W'(tbl[i].exp_ret));
      chk($sformatf("vec%0d.level_1", i),  OBS_W'(bus.level_1_o),  OBS_W'(tbl[i].exp_l1));
      chk($sformatf("vec%0d.level_2", i),  OBS_W'(bus.level_2_o),  OBS_W'(tbl[i].exp_l2));
      chk($sformatf("vec%0d.overflow", i), OBS_W'(bus.overflow_o), OBS_W'(tbl[i].exp_ovf));
      if (tbl[i].exp_ret) begin
        chk($sformatf("vec%0d.obs_1", i), bus.obs_1_o, OBS_W'(tbl[i].exp_o1));
        chk($sformatf("vec%0d.obs_2", i), bus.obs_2_o, OBS_W'(tbl[i].exp_o2));
      end
    end

    // Push into a full run-1 FIFO while a pair pops: accepted, no overflow.
    do_reset("rst_full");
    for (int i = 1; i <= 4; i++) step("full", 1'b1, OBS_W'(8'hE0 + i), 1'b0, '0);
    step("full", 1'b0, '0, 1'b1, OBS_W'(8'hF1));
    chk("full.level_before", OBS_W'(bus.level_1_o), OBS_W'(4));
    step("full", 1'b1, OBS_W'(8'hE5), 1'b0, '0);
    chk("full.level_kept", OBS_W'(bus.level_1_o), OBS_W'(4));
    chk("full.no_overflow", OBS_W'(bus.overflow_o), '0);
    chk("full.first_pair", bus.obs_1_o, OBS_W'(8'hE1));
    for (int i = 2; i <= 5; i++) step("full", 1'b0, '0, 1'b1, OBS_W'(8'hF0 + i));
    idle("full", 1);
    chk("full.last_pair", bus.obs_1_o, OBS_W'(8'hE5));
    chk("full.pairs", OBS_W'(bus.pairs_o), OBS_W'(5));

    // One-sided skew: desync after the 64th skewed edge, pairing continues.
    do_reset("rst_skew");
    step("skew", 1'b1, OBS_W'(8'h5A), 1'b0, '0);
    idle("skew", MAX_SKEW - 1);
    chk("skew.before_limit", OBS_W'(bus.desync_o), '0);
    idle("skew", 1);
    chk("skew.at_limit", OBS_W'(bus.desync_o), OBS_W'(1));
    step("skew", 1'b0, '0, 1'b1, OBS_W'(8'h5B));
    idle("skew", 1);
    chk("skew.pair", OBS_W'(bus.retire_o), OBS_W'(1));
    chk("skew.sticky", OBS_W'(bus.desync_o), OBS_W'(1));

    // Reset with entries pending: nothing stale comes out afterwards.
    do_reset("rst_mid_pre");
    step("mid", 1'b1, OBS_W'(8'h71), 1'b1, OBS_W'(8'h81));
    step("mid", 1'b1, OBS_W'(8'h72), 1'b0, '0);
    step("mid", 1'b1, OBS_W'(8'h73), 1'b0, '0);
    step("mid", 1'b0, '0, 1'b1, OBS_W'(8'h82));
    do_reset("rst_mid");
    idle("post_rst", 3);
    chk("post_rst.no_stale", OBS_W'(bus.pairs_o), '0);
    step("post_rst", 1'b1, OBS_W'(8'h91), 1'b1, OBS_W'(8'h92));
    idle("post_rst", 1);
    chk("post_rst.obs_1", bus.obs_1_o, OBS_W'(8'h91));
    chk("post_rst.obs_2", bus.obs_2_o, OBS_W'(8'h92));

    // Randomized traffic with varying run bias against the model.
    for (int seg = 0; seg < 4; seg++) begin
      int p1, p2;
      do_reset($sformatf("rst_rand%0d", seg));
      p1 = (seg == 1) ? 90 : (seg == 2) ? 15 : (seg == 3) ? 97 : 50;
      p2 = (seg == 1) ? 15 : (seg == 2) ? 90 : (seg == 3) ? 1 : 50;
      for (int c = 0; c < 400; c++) begin
        step($sformatf("rand%0d", seg),
             ($urandom_range(99) < p1), rand_obs(),
             ($urandom_range(99) < p2), rand_obs());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
